// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, decoded operations and
// writeback-stage state encoding plus small operation classifiers.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_ADDI,
    OP_CSR,
    OP_JAL,
    OP_JALR,
    OP_LB,
    OP_LH,
    OP_LW,
    OP_LBU,
    OP_LHU,
    OP_STORE,
    OP_BRANCH
  } operation_e;

  typedef enum logic {
    WB_IDLE,
    WB_WAIT_LOAD
  } wb_state_e;

  function automatic logic is_load(input operation_e op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_link(input operation_e op);
    return op inside {OP_JAL, OP_JALR};
  endfunction

  // Stores and branches retire without producing a destination value
  function automatic logic writes_rd(input operation_e op);
    return !(op inside {OP_STORE, OP_BRANCH});
  endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the addressed byte/halfword/word from a naturally aligned load
// response and sign- or zero-extends it to the datapath width.
module load_extract #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  riscv_pkg::operation_e operation,
  input  logic [1:0]            addr_lo,
  input  logic [XLEN-1:0]       rdata,
  output logic [XLEN-1:0]       result
);
  import riscv_pkg::*;

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_v;

  // Lanes live in the low 32 bits; a 64-bit LW still sign-extends bit 31
  always_comb begin
    byte_v = rdata[{addr_lo, 3'b000} +: 8];
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    word_v = rdata[31:0];
    case (operation)
      OP_LB:   result = XLEN'($signed(byte_v));
      OP_LBU:  result = XLEN'(byte_v);
      OP_LH:   result = XLEN'($signed(half_v));
      OP_LHU:  result = XLEN'(half_v);
      OP_LW:   result = XLEN'($signed(word_v));
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Registered writeback stage: handshakes with MEM, waits for late load data,
// drives the register-file write port and counts retired instructions.
module wb_stage #(
  parameter int unsigned XLEN       = riscv_pkg::XLEN,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  riscv_pkg::operation_e operation_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic [XLEN-1:0]       rd_data_i,
  input  logic [XLEN-1:0]       pc_plus4_i,
  input  logic [1:0]            addr_lo_i,
  input  logic                  mem_rvalid_i,
  input  logic [XLEN-1:0]       mem_rdata_i,
  input  logic                  flush_i,
  output logic                  rf_we_o,
  output logic [REG_ADDR_W-1:0] rf_waddr_o,
  output logic [XLEN-1:0]       rf_wdata_o,
  output logic                  retire_o,
  output logic [CNT_W-1:0]      instret_o,
  output logic                  stray_rsp_o
);
  import riscv_pkg::*;

  wb_state_e             state;
  operation_e            pend_op;
  logic [REG_ADDR_W-1:0] pend_rd;
  logic [1:0]            pend_lo;
  logic                  drop_q;

  operation_e            ext_op;
  logic [1:0]            ext_lo;
  logic [XLEN-1:0]       ext_data;
  logic                  accept;
  logic                  rsp_live;

  assign ready_o = (state == WB_IDLE);

  // A response consumed by the drop flag never counts as load data
  always_comb begin
    accept   = valid_i & ready_o & ~flush_i;
    rsp_live = mem_rvalid_i & ~drop_q;
    ext_op   = (state == WB_WAIT_LOAD) ? pend_op : operation_i;
    ext_lo   = (state == WB_WAIT_LOAD) ? pend_lo : addr_lo_i;
  end

  load_extract #(
    .XLEN(XLEN)
  ) u_extract (
    .operation(ext_op),
    .addr_lo  (ext_lo),
    .rdata    (mem_rdata_i),
    .result   (ext_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= WB_IDLE;
      pend_op     <= OP_ADD;
      pend_rd     <= '0;
      pend_lo     <= '0;
      drop_q      <= 1'b0;
      rf_we_o     <= 1'b0;
      rf_waddr_o  <= '0;
      rf_wdata_o  <= '0;
      retire_o    <= 1'b0;
      instret_o   <= '0;
      stray_rsp_o <= 1'b0;
    end else begin
      rf_we_o  <= 1'b0;
      retire_o <= 1'b0;
      if (retire_o) instret_o <= instret_o + CNT_W'(1);

      case (state)
        WB_IDLE: begin
          if (accept && is_load(operation_i) && !rsp_live) begin
            state   <= WB_WAIT_LOAD;
            pend_op <= operation_i;
            pend_rd <= rd_addr_i;
            pend_lo <= addr_lo_i;
          end else if (accept) begin
            retire_o   <= 1'b1;
            rf_we_o    <= writes_rd(operation_i) && (rd_addr_i != '0);
            rf_waddr_o <= rd_addr_i;
            rf_wdata_o <= is_link(operation_i) ? pc_plus4_i :
                          is_load(operation_i) ? ext_data   : rd_data_i;
          end
          if (mem_rvalid_i) begin
            if (drop_q) drop_q <= 1'b0;
            else if (!(accept && is_load(operation_i))) stray_rsp_o <= 1'b1;
          end
        end

        WB_WAIT_LOAD: begin
          // An abandoned load still owes a response unless it arrives right now
          if (flush_i) begin
            state  <= WB_IDLE;
            drop_q <= drop_q | ~mem_rvalid_i;
          end else if (mem_rvalid_i) begin
            if (drop_q) begin
              drop_q <= 1'b0;
            end else begin
              state      <= WB_IDLE;
              retire_o   <= 1'b1;
              rf_we_o    <= (pend_rd != '0);
              rf_waddr_o <= pend_rd;
              rf_wdata_o <= ext_data;
            end
          end
        end

        default: state <= WB_IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Registered writeback stage between the memory stage and the register file. It replaces the purely combinational result select with several additions: a valid/ready handshake, a wait state for late load responses, byte/halfword extraction with sign or zero extension, x0 write suppression, flush handling and a retired-instruction counter. It drives the register-file write port and the WB forwarding path.

## Interface
Parameters:
- XLEN, 32: datapath width; must be 32 or 64.
- REG_ADDR_W, 5: register index width.
- CNT_W, 64: retired-instruction counter width.

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- valid_i  in  1  MEM stage presents an instruction
- ready_o  out  1  stage can accept; high only in IDLE
- operation_i  in  operation_e  decoded operation
- rd_addr_i  in  REG_ADDR_W  destination register
- rd_data_i  in  XLEN  ALU/CSR result
- pc_plus4_i  in  XLEN  link value for JAL/JALR
- addr_lo_i  in  2  low bits of load address
- mem_rvalid_i  in  1  load response valid
- mem_rdata_i  in  XLEN  raw load word (naturally aligned)
- flush_i  in  1  discard pending/accepting instruction
- rf_we_o  out  1  register-file write enable (one-cycle pulse)
- rf_waddr_o  out  REG_ADDR_W  write address
- rf_wdata_o  out  XLEN  write data
- retire_o  out  1  one-cycle pulse per retired instruction
- instret_o  out  CNT_W  retired count
- stray_rsp_o  out  1  sticky: response with no outstanding load

## Operation
- States: IDLE, WAIT_LOAD.
- Accept = valid_i & ready_o & !flush_i.
- Non-load accepted:
  - Next cycle: rf_we_o=1 (0 if rd_addr_i==0) and retire_o=1.
  - Data: pc_plus4_i for JAL/JALR; otherwise rd_data_i.
  - Stores and branches (no rd): retire_o=1, rf_we_o=0.
- Load accepted with mem_rvalid_i in the same cycle: behaves like a non-load, with extracted data.
- Load accepted without mem_rvalid_i: go to WAIT_LOAD; latch operation, rd_addr, addr_lo.
  - WAIT_LOAD + mem_rvalid_i: write/retire next cycle, return to IDLE.
- Extraction uses the byte at addr_lo and the halfword at addr_lo[1]:
  - LB/LH: sign-extend to XLEN.
  - LBU/LHU: zero-extend.
  - LW: low 32 bits; for XLEN=64, sign-extend.
  - Misalignment is not checked here.
- Flush:
  - flush_i in IDLE blocks the accept.
  - flush_i in WAIT_LOAD abandons the load: no write, no retire, back to IDLE, set drop flag.
  - Drop flag: the next mem_rvalid_i is silently consumed, then the flag clears. A response in the same cycle as the flush is consumed and does not set the flag.
- Stray response (mem_rvalid_i in IDLE, drop flag clear, no load being accepted) sets stray_rsp_o until reset.
- instret_o increments by 1 on every retire_o and wraps modulo 2^CNT_W.

## Timing
- Reset values:
  - State IDLE, ready_o=1.
  - rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0.
  - retire_o=0, instret_o=0, stray_rsp_o=0, drop flag 0.
- Latency: accept to rf_we_o is 1 cycle for non-loads and same-cycle loads; otherwise 1 cycle after mem_rvalid_i.
- All outputs are registered; ready_o is decoded from state only.
- Throughput: 1 instruction/cycle when no load waits.
- Reset asserted mid-WAIT_LOAD returns to IDLE immediately. A response arriving after reset deasserts is stray.

## Structure
- In riscv_pkg:
  - Add a wb_state_e enum.
  - Add an is_load(operation_e) function.
  - XLEN and operation_e already live there.
- Sub-module load_extract: combinational; takes (operation, addr_lo, rdata) and returns the extended value.
- The top module holds the FSM, pipeline registers, counter and flags.

## Test plan
- ADDI x5 result 0x0000_0010: rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x10 one cycle later; instret_o 0→1.
- JAL rd=1, pc_plus4=0x104: rf_wdata_o=0x104. ADD rd=0 then produces rf_we_o=0, retire_o=1.
- LB addr_lo=2, rdata 0x0080_0000, response 3 cycles late:
  - ready_o low for 3 cycles.
  - rf_wdata_o=0xFFFF_FF80.
  - LBU of the same data gives 0x80; LH addr_lo=2 of 0x8001_0000 gives 0xFFFF_8001.
- Back-to-back ADDs for 4 cycles: 4 consecutive write pulses, instret_o=4.
- Load waiting, flush_i pulse, response two cycles later:
  - No write, no retire.
  - stray_rsp_o stays 0.
  - A second unexpected response sets stray_rsp_o=1.
- rst_ni asserted in WAIT_LOAD: all outputs return to reset values asynchronously, ready_o=1.
